// File: rtl/d_line_bridge_if.sv
// Word-beat bus between the line bridge and main memory.
// The bridge is master; ram_rdata is valid with ram_ack on reads.
interface d_line_bridge_if;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_ack;
    logic [31:0] ram_rdata;

    modport master (
        output ram_req, ram_we, ram_addr, ram_wdata,
        input  ram_ack, ram_rdata
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_wdata,
        output ram_ack, ram_rdata
    );
endinterface

// File: rtl/d_line_bridge.sv
// Splits 128-bit cache line refills/write-backs into four 32-bit beats.
// Optional per-beat timeout: define D_LINE_BRIDGE_TIMEOUT_EN.
module d_line_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_r,
    input  logic          mem_w,
    input  logic [31:0]   mem_addr,
    input  logic [127:0]  mem_data_out,
    output logic [127:0]  mem_data,
    output logic          mem_ready,
    output logic          bus_err,
    d_line_bridge_if.master ram
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        beat;
    logic [1:0]        nbeat;
    logic [27:0]       base;
    logic [3:0][31:0]  wline;
    logic              ack;

    assign nbeat = beat + 2'd1;
    assign ack   = ram.ram_req & ram.ram_ack;

    // Low address nibble is dropped: transfers are always line aligned.
    logic unused_addr;
    assign unused_addr = ^mem_addr[3:0];

`ifdef D_LINE_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wcnt;
`else
    logic [31:0] unused_to;
    assign unused_to = 32'(TIMEOUT_CYCLES);
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            beat          <= 2'd0;
            base          <= '0;
            wline         <= '0;
            mem_data      <= '0;
            mem_ready     <= 1'b0;
            ram.ram_req   <= 1'b0;
            ram.ram_we    <= 1'b0;
            ram.ram_addr  <= '0;
            ram.ram_wdata <= '0;
`ifdef D_LINE_BRIDGE_TIMEOUT_EN
            bus_err       <= 1'b0;
            wcnt          <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_w || mem_r) begin
                        state         <= mem_w ? WR : RD;
                        base          <= mem_addr[31:4];
                        wline         <= mem_data_out;
                        beat          <= 2'd0;
                        ram.ram_req   <= 1'b1;
                        ram.ram_we    <= mem_w;
                        ram.ram_addr  <= {mem_addr[31:4], 4'b0};
                        ram.ram_wdata <= mem_data_out[31:0];
`ifdef D_LINE_BRIDGE_TIMEOUT_EN
                        bus_err       <= 1'b0;
                        wcnt          <= '0;
`endif
                    end
                end
                RD, WR: begin
                    if (ack) begin
                        if (state == RD)
                            mem_data[{beat, 5'd0} +: 32] <= ram.ram_rdata;
                        beat <= nbeat;
`ifdef D_LINE_BRIDGE_TIMEOUT_EN
                        wcnt <= '0;
`endif
                        if (beat == 2'd3) begin
                            state       <= DONE;
                            ram.ram_req <= 1'b0;
                            ram.ram_we  <= 1'b0;
                            mem_ready   <= 1'b1;
                        end else begin
                            ram.ram_addr  <= {base, nbeat, 2'b00};
                            ram.ram_wdata <= wline[nbeat];
                        end
                    end
`ifdef D_LINE_BRIDGE_TIMEOUT_EN
                    else if (wcnt == TO_LAST) begin
                        // Abort: report completion with the partial line.
                        state       <= DONE;
                        ram.ram_req <= 1'b0;
                        ram.ram_we  <= 1'b0;
                        mem_ready   <= 1'b1;
                        bus_err     <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/d_line_bridge.md
# d_line_bridge

Converts the data cache's 128-bit line-transfer requests (refill and write-back) into four sequential 32-bit word beats on the main-memory bus. It sits directly downstream of the data cache, on its memory side. It presents the assembled line to the cache with a one-cycle `mem_ready` pulse.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: per-beat wait limit in cycles. Used only when the timeout feature is compiled in. Legal range 2..255.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `mem_r` in 1: line read (refill) request from cache; held until `mem_ready`.
- `mem_w` in 1: line write (write-back) request from cache; held until `mem_ready`.
- `mem_addr` in 32: line address; bits [3:0] are ignored and forced to 0.
- `mem_data_out` in 128: line to write; word i is bits [32i+31:32i].
- `mem_data` out 128: assembled read line, same word layout.
- `mem_ready` out 1: one-cycle completion pulse.
- `bus_err` out 1: last transfer aborted by timeout.
- `ram_req` out 1: beat request to main memory.
- `ram_we` out 1: beat is a write.
- `ram_addr` out 32: beat byte address.
- `ram_wdata` out 32: beat write data.
- `ram_ack` in 1: beat accepted/completed. For reads, `ram_rdata` is valid in the same cycle.
- `ram_rdata` in 32: beat read data.

## Operation
- States: IDLE, RD, WR, DONE.
- **IDLE:** `ram_req`=0. On `mem_w`=1, go to WR. Otherwise, on `mem_r`=1, go to RD. `mem_w` has priority when both are high.
- **Accept (IDLE exit):** latch the line base `{mem_addr[31:4],4'b0}`, latch `mem_data_out`, clear the beat counter, clear `bus_err`.
- **RD/WR:**
  - `ram_req`=1, `ram_addr`=base+4*beat, `ram_we`=1 in WR.
  - `ram_wdata`=latched word[beat].
  - These outputs are registered and stable while `ram_ack`=0.
- **Beat completion:** a beat completes in a cycle where `ram_req`&`ram_ack`.
  - RD writes `ram_rdata` into line-buffer word[beat].
  - The beat counter (2-bit) increments.
  - After beat 3 completes, go to DONE.
- **DONE:**
  - `mem_ready`=1 and `ram_req`=0 for exactly one cycle, then IDLE.
  - `mem_data` = line buffer. It holds its value until the next RD beat overwrites it; it is not cleared between transfers.
- **Request sampling:** requests are sampled only in IDLE. A request still asserted during DONE is not re-accepted that cycle. The cache changes `mem_r`/`mem_w` on the edge that ends DONE, so back-to-back write-back then refill is accepted in the following IDLE cycle.
- **Ignored inputs:** `ram_ack` while `ram_req`=0 is ignored.
- **Reset (`rst`=0, any state, including mid-burst):**
  - Immediately: state IDLE, `ram_req`=0, `ram_we`=0, `mem_ready`=0, `bus_err`=0.
  - `ram_addr`=0, `ram_wdata`=0, `mem_data`=0, beat counter=0.
  - The partial burst is dropped; no retry.

## Timing
- **Zero-wait memory:**
  - Request high in cycle 0 (IDLE).
  - Beats in cycles 1–4.
  - `mem_ready` in cycle 5.
  - Latency 5 cycles from first sampled request.
- **Wait states:** each wait cycle on a beat adds one cycle; latency = 5 + total wait cycles.
- **Back-to-back beats:** `ram_req` stays high; the address advances on the edge after each ack.
- **Output timing:** all outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Feature macro: `D_LINE_BRIDGE_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit wait counter resets on accept and on each ack, and increments on each RD/WR cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES` without ack, drop `ram_req` and go to DONE with `bus_err`=1.
  - `mem_ready` pulses normally. `mem_data` holds the partially filled buffer.
  - `bus_err` stays 1 until the next accept or reset.
- **Undefined:** waits indefinitely for `ram_ack`; `bus_err` is constant 0 and no counter is present.

## Test plan
- Reset mid-burst: assert `rst`=0 during RD beat 2 -> `ram_req`=0 and `mem_ready`=0 at once; IDLE after release; next request restarts at beat 0.
- Zero-wait read:
  - Stimulus: `mem_r`=1, `mem_addr`=0x0000_1234, `ram_ack` tied 1, `ram_rdata`=0xA0+beat.
  - Required: `ram_addr` 0x1230, 0x1234, 0x1238, 0x123C.
  - Required: `mem_ready` in cycle 5, `mem_data`=0x000000A3_000000A2_000000A1_000000A0.
- Write with waits:
  - Stimulus: `mem_w`=1, `mem_addr`=0x8000_0040, line=0x44..._33..._22..._11..., 2 wait cycles per beat.
  - Required: `ram_we`=1, `ram_wdata`=0x11111111 first, stable through waits.
  - Required: `mem_ready` at cycle 13.
- Simultaneous `mem_r`=`mem_w`=1 -> write burst executes (`ram_we`=1); no read beats.
- Back-to-back write-back then refill:
  - Stimulus: `mem_w` held through DONE, then switched to `mem_r`.
  - Required: exactly one write burst, then one read burst; second `mem_ready` 5 cycles after the first IDLE.
- With `D_LINE_BRIDGE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `ram_ack` never asserted -> `ram_req` drops after 4 wait cycles; `mem_ready`=1 and `bus_err`=1; `bus_err` clears on the next accept.
